// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg
//   Shared types and sizing helpers for the FIFO write-side arbiter.
//   - arb_state_e : arbiter FSM states (IDLE: no owner, GRANT: owner holds port)
//   - id_width(n) : width of a requester index, max(1, clog2(n))
//   - cnt_width(m): width of the per-grant beat counter for MAX_BURST = m
//
// Optional feature macro used by the arbiter: FIFO_WR_ARB_TAG_EN
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width for NREQ requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Beat counter spans 0..MAX_BURST-1; never narrower than one bit.
  function automatic int cnt_width(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin priority pick over an NREQ-wide request mask.
//   The search starts at rr_ptr and walks upward, wrapping modulo NREQ; the
//   first set mask bit wins.
//
// Ports:
//   mask   in  NREQ  candidate requesters
//   rr_ptr in  IDW   search start position
//   found  out 1     at least one mask bit is set
//   idx    out IDW   winning requester index (0 when nothing found)
module rr_picker
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] mask,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  localparam int unsigned N = NREQ;

  always_comb begin
    int unsigned pos;
    logic [IDW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Wrap by subtraction: rr_ptr < N and k < N, so one correction suffices.
      pos = 32'(rr_ptr) + k;
      if (pos >= N) pos = pos - N;
      cand = IDW'(pos);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of an async FIFO among NREQ requesters in
//   the write clock domain. Grants round-robin, holds each grant for at most
//   MAX_BURST beats, and never writes while wfull is high.
//
// Parameters:
//   NREQ      number of requesters (2..16)
//   DSIZE     data width per beat (matches FIFO DSIZE)
//   MAX_BURST maximum beats per grant (1..256)
//
// Ports:
//   clk       in   1            write clock (FIFO wclk)
//   rst       in   1            synchronous active-high reset
//   req_valid in   NREQ         per-requester beat valid
//   req_data  in   NREQ*DSIZE   requester i data at [i*DSIZE +: DSIZE]
//   req_ready out  NREQ         per-requester beat accepted
//   wfull     in   1            FIFO full flag
//   winc      out  1            FIFO write strobe
//   wdata     out  DSIZE(+IDW)  FIFO write data
//   grant_id  out  IDW          current owner index
//   busy      out  1            a grant is held
//
// Configuration macro: FIFO_WR_ARB_TAG_EN
//   defined   -> wdata = {grant_id, data}, DSIZE+IDW bits wide
//   undefined -> wdata = data, DSIZE bits wide
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DSIZE     = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = id_width(NREQ),
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int WW        = DSIZE + IDW
`else
  localparam int WW        = DSIZE
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [WW-1:0]         wdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(MAX_BURST);

  arb_state_e       r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_grant_id;
  logic [CNT_W-1:0] r_beat_cnt;

  logic             w_granted;
  logic             w_own_valid;
  logic             w_xfer;
  logic             w_last;
  logic             w_release;
  logic [IDW-1:0]   w_next_ptr;
  logic [NREQ-1:0]  w_pick_mask;
  logic [IDW-1:0]   w_pick_ptr;
  logic             w_found;
  logic [IDW-1:0]   w_pick_idx;
  logic [DSIZE-1:0] w_data;

  assign w_granted   = (r_state == GRANT);
  assign w_own_valid = req_valid[r_grant_id];
  assign w_xfer      = w_granted && w_own_valid && !wfull;
  assign w_last      = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  // Owner dropping valid releases even under wfull; a full burst only
  // releases on the beat that actually transfers.
  assign w_release   = w_granted && ((w_xfer && w_last) || !w_own_valid);
  assign w_next_ptr  = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;

  // One picker serves both paths: from IDLE it searches all requesters from
  // rr_ptr; on release it searches from owner+1 with the owner masked off,
  // which is exactly where rr_ptr is being moved to.
  assign w_pick_mask = w_granted ? (req_valid & ~(NREQ'(1) << r_grant_id)) : req_valid;
  assign w_pick_ptr  = w_granted ? w_next_ptr : r_rr_ptr;

  rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .mask   (w_pick_mask),
    .rr_ptr (w_pick_ptr),
    .found  (w_found),
    .idx    (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= GRANT;
            r_grant_id <= w_pick_idx;
            r_beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= '0;
            if (w_found) begin
              r_grant_id <= w_pick_idx;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_granted && !wfull) req_ready[r_grant_id] = 1'b1;
  end

  assign w_data   = req_data[r_grant_id*DSIZE +: DSIZE];
  assign winc     = w_xfer;
  assign grant_id = r_grant_id;
  assign busy     = w_granted;

`ifdef FIFO_WR_ARB_TAG_EN
  assign wdata = {r_grant_id, w_data};
`else
  assign wdata = w_data;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the async FIFO among `NREQ` requesters in the write clock domain. It grants requesters round-robin, holds each grant for a bounded burst, and drives the FIFO `winc`/`wdata` directly. It respects `wfull` so that no beat is ever lost. It sits between the requester fabric and the FIFO write port, in the same clock domain as `wfull`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..16.
- `DSIZE`, 8: data width per beat; must match the FIFO `DSIZE`.
- `MAX_BURST`, 4: maximum beats per grant, 1..256.

Ports:
- `clk`  in  1  write clock; the same clock as the FIFO `wclk`.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `req_valid`  in  NREQ  per-requester beat valid.
- `req_data`  in  NREQ*DSIZE  requester i's data in bits `[i*DSIZE +: DSIZE]`.
- `req_ready`  out  NREQ  per-requester beat accepted.
- `wfull`  in  1  FIFO full flag.
- `winc`  out  1  FIFO write strobe.
- `wdata`  out  DSIZE (+IDW with tag)  FIFO write data.
- `grant_id`  out  IDW  index of the current owner; IDW = max(1, clog2(NREQ)).
- `busy`  out  1  a grant is held.

## Operation
- Two states:
  - IDLE: no owner.
  - GRANT: `grant_id` owns the port.
- Beat transfer: a beat transfers in a cycle when the state is GRANT, `req_valid[grant_id]` is 1 and `wfull` is 0.
  - `winc` = transfer.
  - `req_ready[grant_id]` = GRANT & ~`wfull`.
  - All other `req_ready` bits are 0.
  - `wdata` = `req_data` slice of `grant_id` (combinational mux, always driven).
- Pick function: the first `req_valid` bit searched from `rr_ptr` upward, wrapping modulo NREQ.
- IDLE → GRANT: on the edge where any `req_valid` is 1.
  - `grant_id` ← pick.
  - `beat_cnt` ← 0.
- GRANT, transfer without release: `beat_cnt` increments.
- Release happens at an edge when either of these holds:
  - a transfer occurs with `beat_cnt` == MAX_BURST-1; or
  - `req_valid[grant_id]` is 0.
- At release:
  - `rr_ptr` ← `grant_id`+1 (mod NREQ).
  - If another requester (excluding the releasing owner) is valid, the next state is GRANT to the pick from the new `rr_ptr`, with `beat_cnt` ← 0. There is no idle bubble.
  - Otherwise the next state is IDLE.
- `wfull` = 1 while in GRANT: `beat_cnt` holds, the grant is kept, and no release occurs while the owner's valid stays high.
- A requester must hold `req_valid` and `req_data` stable until `req_ready`. Dropping `req_valid` releases its grant.
- Reset values:
  - state IDLE
  - `rr_ptr` 0
  - `grant_id` 0
  - `beat_cnt` 0
  - `busy` 0
  - `winc` 0
  - `req_ready` all 0

## Timing
- Requester valid in IDLE: first `winc` 1 cycle later, provided `wfull`=0.
- Back-to-back grants: the new owner may write in the cycle right after the previous owner's last beat.
- Throughput: 1 beat per cycle while `wfull`=0.
- `winc` is combinational from `req_valid`/`wfull` and the registered state. There is no combinational path from `req_valid` to `grant_id`.
- `wfull` rising in the same cycle as a pending beat: no `winc`. The beat stays pending.
- `rst` asserted mid-burst: all outputs return to reset values at the next edge. Partial bursts are not resumed.

## Configuration
- Macro: `FIFO_WR_ARB_TAG_EN`.
- Defined: `wdata` is DSIZE+IDW wide, formatted as {`grant_id`, data}. The FIFO must be instantiated with DSIZE+IDW.
- Undefined: `wdata` is DSIZE wide and carries data only.
- Arbitration behaviour is identical in both cases.

## Structure
- Package `fifo_wr_arb_pkg`:
  - state enum (IDLE, GRANT)
  - `id_width(n)` function returning IDW
  - `beat_cnt` width constant derived from MAX_BURST
- Sub-module `rr_picker`: combinational NREQ-wide round-robin priority pick. Inputs are the mask and `rr_ptr`; outputs are `found` and `idx`. It is shared by the IDLE and release paths.

## Test plan
- Single requester: NREQ=4, MAX_BURST=4, `req_valid`=4'b0001 with 6 beats 0x10..0x15, `wfull`=0 → beats are written in order.
  - `winc` is high on 4 cycles; a release occurs; the grant is re-acquired by requester 0 the next cycle.
  - No data is lost or duplicated.
- Round-robin: all four requesters valid continuously, MAX_BURST=2 → grant order 0,1,2,3,0 with 2 beats each and no idle cycles.
- Backpressure: `wfull`=1 for 3 cycles mid-burst after beat 1 → `winc` and `req_ready` are 0 for those 3 cycles. `beat_cnt` holds at 1 and the grant is kept. Beat 2 is written on the first cycle with `wfull`=0.
- Early release: requester 2 drops `req_valid` after 1 beat of 4 while requester 3 is valid → the grant moves to 3 on the next edge and `rr_ptr`=3.
- Reset mid-burst: `rst` is pulsed during requester 1's beat 2 → `busy`=0, `winc`=0 and `req_ready`=0 after the edge. With requesters 1 and 3 then valid, the grant goes to 1 first (`rr_ptr`=0).
- Tag build: with `FIFO_WR_ARB_TAG_EN` defined, requester 3 writes 0xA5 → `wdata`=10'h3A5 for NREQ=4, DSIZE=8.
